// File: rtl/scale_pkg.sv
// rtl/scale_pkg.sv - shared widths, state encoding and constants for the coordinate generator
package scale_pkg;
  localparam int AW   = 11;
  localparam int KW   = 16;
  localparam int FW   = 8;
  localparam int ACCW = AW + KW;

  localparam logic [KW-1:0] K_UNITY = 16'd256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/scale_coord_gen_if.sv
// rtl/scale_coord_gen_if.sv - frame parameters in, coordinate stream out
interface scale_coord_gen_if;
  import scale_pkg::*;

  logic          frame_start;
  logic [AW-1:0] t_width;
  logic [AW-1:0] t_height;
  logic [AW-1:0] s_width;
  logic [AW-1:0] s_height;
  logic [KW-1:0] h_scale_k;
  logic [KW-1:0] v_scale_k;
  logic          coord_valid;
  logic          coord_ready;
  logic [AW-1:0] dst_x;
  logic [AW-1:0] dst_y;
  logic [AW-1:0] src_x;
  logic [AW-1:0] src_y;
  logic [FW-1:0] frac_x;
  logic [FW-1:0] frac_y;
  logic          line_end;
  logic          frame_end;
  logic          frame_done;
  logic          busy;

  modport slave (
    input  frame_start, t_width, t_height, s_width, s_height, h_scale_k, v_scale_k, coord_ready,
    output coord_valid, dst_x, dst_y, src_x, src_y, frac_x, frac_y,
           line_end, frame_end, frame_done, busy
  );

  modport master (
    output frame_start, t_width, t_height, s_width, s_height, h_scale_k, v_scale_k, coord_ready,
    input  coord_valid, dst_x, dst_y, src_x, src_y, frac_x, frac_y,
           line_end, frame_end, frame_done, busy
  );
endinterface

// File: rtl/scale_axis_acc.sv
// rtl/scale_axis_acc.sv - one axis: 8.8 step accumulator with integer/fraction split and source clamp
module scale_axis_acc
  import scale_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          clear_i,
  input  logic          step_i,
  input  logic [KW-1:0] k_i,
  input  logic [AW-1:0] s_size_i,
  output logic [AW-1:0] src_o,
  output logic [FW-1:0] frac_o
);
  logic [ACCW-1:0]    acc_q, acc_d;
  logic [KW-1:0]      k_q;
  logic [AW-1:0]      s_size_q;
  logic [AW-1:0]      s_max;
  logic [ACCW-FW-1:0] int_part;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      k_q      <= '0;
      s_size_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (load_i) begin
        k_q      <= k_i;
        s_size_q <= s_size_i;
      end
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (load_i || clear_i) acc_d = '0;
    else if (step_i)       acc_d = acc_q + ACCW'(k_q);
  end

  assign s_max    = s_size_q - AW'(1);
  assign int_part = acc_q[ACCW-1:FW];

  // Past the last source pixel there is no right/bottom neighbour, so weight collapses to zero.
  always_comb begin
    src_o  = int_part[AW-1:0];
    frac_o = acc_q[FW-1:0];
    if (s_size_q == '0) begin
      src_o  = '0;
      frac_o = '0;
    end else if (int_part > {{(ACCW-FW-AW){1'b0}}, s_max}) begin
      src_o  = s_max;
      frac_o = '0;
    end
  end
endmodule

// File: rtl/scale_coord_gen.sv
// rtl/scale_coord_gen.sv - raster walker over the target frame emitting clamped source coordinates
module scale_coord_gen
  import scale_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  scale_coord_gen_if.slave  sif
);
  state_e        state_q, state_d;
  logic [AW-1:0] t_w_q, t_h_q;
  logic [AW-1:0] dst_x_q, dst_x_d;
  logic [AW-1:0] dst_y_q, dst_y_d;
  logic          fs_ok, run, xfer, line_end_w, frame_end_w;

  // A restart takes priority over a transfer landing in the same cycle.
  assign fs_ok       = sif.frame_start && (sif.t_width != '0) && (sif.t_height != '0);
  assign run         = (state_q == ST_RUN);
  assign xfer        = run && sif.coord_ready && !fs_ok;
  assign line_end_w  = (dst_x_q == t_w_q - AW'(1));
  assign frame_end_w = line_end_w && (dst_y_q == t_h_q - AW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      t_w_q   <= '0;
      t_h_q   <= '0;
      dst_x_q <= '0;
      dst_y_q <= '0;
    end else begin
      state_q <= state_d;
      dst_x_q <= dst_x_d;
      dst_y_q <= dst_y_d;
      if (fs_ok) begin
        t_w_q <= sif.t_width;
        t_h_q <= sif.t_height;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dst_x_d = dst_x_q;
    dst_y_d = dst_y_q;
    case (state_q)
      ST_IDLE: if (fs_ok) state_d = ST_RUN;
      ST_RUN: begin
        if (fs_ok)                    state_d = ST_RUN;
        else if (xfer && frame_end_w) state_d = ST_DONE;
      end
      ST_DONE: state_d = fs_ok ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (fs_ok) begin
      dst_x_d = '0;
      dst_y_d = '0;
    end else if (xfer) begin
      if (line_end_w) begin
        dst_x_d = '0;
        dst_y_d = frame_end_w ? '0 : dst_y_q + AW'(1);
      end else begin
        dst_x_d = dst_x_q + AW'(1);
      end
    end
  end

  scale_axis_acc u_acc_x (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (fs_ok),
    .clear_i  (xfer && line_end_w),
    .step_i   (xfer && !line_end_w),
    .k_i      (sif.h_scale_k),
    .s_size_i (sif.s_width),
    .src_o    (sif.src_x),
    .frac_o   (sif.frac_x)
  );

  scale_axis_acc u_acc_y (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (fs_ok),
    .clear_i  (xfer && frame_end_w),
    .step_i   (xfer && line_end_w && !frame_end_w),
    .k_i      (sif.v_scale_k),
    .s_size_i (sif.s_height),
    .src_o    (sif.src_y),
    .frac_o   (sif.frac_y)
  );

  assign sif.coord_valid = run;
  assign sif.busy        = run;
  assign sif.frame_done  = (state_q == ST_DONE);
  assign sif.line_end    = run && line_end_w;
  assign sif.frame_end   = run && frame_end_w;
  assign sif.dst_x       = dst_x_q;
  assign sif.dst_y       = dst_y_q;
endmodule

// File: tb/tb_scale_coord_gen.sv
// tb/tb_scale_coord_gen.sv - randomized and directed checks of scale_coord_gen against an arithmetic model
module tb_scale_coord_gen;
  import scale_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scale_coord_gen_if sif();

  scale_coord_gen u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  int n_vec = 0;
  int n_err = 0;
  int lt_tw, lt_th, lt_sw, lt_sh, lt_hk, lt_vk;
  bit fin;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Source position of target index d is simply d*k in 8.8, then clamped.
  function automatic void axis_model(input int d, input int k, input int s,
                                     output int src, output int frac);
    longint acc;
    int     ip;
    acc = longint'(d) * longint'(k);
    ip  = int'(acc / 256);
    if (s == 0) begin
      src = 0; frac = 0;
    end else if (ip > s - 1) begin
      src = s - 1; frac = 0;
    end else begin
      src = ip; frac = int'(acc % 256);
    end
  endfunction

  task automatic scramble_inputs();
    sif.t_width   = AW'($urandom);
    sif.t_height  = AW'($urandom);
    sif.s_width   = AW'($urandom);
    sif.s_height  = AW'($urandom);
    sif.h_scale_k = KW'($urandom);
    sif.v_scale_k = KW'($urandom);
  endtask

  task automatic start_frame(input int tw, input int th, input int sw, input int sh,
                             input int hk, input int vk);
    sif.t_width   = AW'(tw);
    sif.t_height  = AW'(th);
    sif.s_width   = AW'(sw);
    sif.s_height  = AW'(sh);
    sif.h_scale_k = KW'(hk);
    sif.v_scale_k = KW'(vk);
    if (tw != 0 && th != 0) begin
      lt_tw = tw; lt_th = th; lt_sw = sw; lt_sh = sh; lt_hk = hk; lt_vk = vk;
    end
    sif.frame_start = 1'b1;
    @(posedge clk);
    #1;
    sif.frame_start = 1'b0;
    scramble_inputs();
  endtask

  // mode 0: always ready, 1: random ready, 2: five-cycle stall at (2,0)
  task automatic walk(input int n_limit, input int mode, output bit finished);
    int ex_x = 0, ex_y = 0, cnt = 0, cyc = 0, stall = 0;
    int sx, fx, sy, fy;
    bit le, fe, rdy;
    finished = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc > 5000) begin
        chk("walk_cycle_budget", cyc, 5000);
        return;
      end
      axis_model(ex_x, lt_hk, lt_sw, sx, fx);
      axis_model(ex_y, lt_vk, lt_sh, sy, fy);
      le = (ex_x == lt_tw - 1);
      fe = le && (ex_y == lt_th - 1);
      chk("coord_valid", int'(sif.coord_valid), 1);
      chk("busy", int'(sif.busy), 1);
      chk("frame_done_in_run", int'(sif.frame_done), 0);
      chk("dst_x", int'(sif.dst_x), ex_x);
      chk("dst_y", int'(sif.dst_y), ex_y);
      chk("src_x", int'(sif.src_x), sx);
      chk("frac_x", int'(sif.frac_x), fx);
      chk("src_y", int'(sif.src_y), sy);
      chk("frac_y", int'(sif.frac_y), fy);
      chk("line_end", int'(sif.line_end), int'(le));
      chk("frame_end", int'(sif.frame_end), int'(fe));
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: begin
          rdy = 1'b1;
          if (ex_x == 2 && ex_y == 0 && stall < 5) begin
            rdy = 1'b0;
            stall++;
          end
        end
      endcase
      sif.coord_ready = rdy;
      @(posedge clk);
      #1;
      if (rdy) begin
        cnt++;
        if (fe) begin
          finished = 1'b1;
          return;
        end
        if (le) begin
          ex_x = 0;
          ex_y++;
        end else begin
          ex_x++;
        end
        if (cnt == n_limit) return;
      end
    end
  endtask

  task automatic expect_done_pulse();
    @(negedge clk);
    chk("frame_done_pulse", int'(sif.frame_done), 1);
    chk("valid_in_done", int'(sif.coord_valid), 0);
    chk("busy_in_done", int'(sif.busy), 0);
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    chk({tag, "_frame_done"}, int'(sif.frame_done), 0);
    chk({tag, "_busy"}, int'(sif.busy), 0);
    chk({tag, "_valid"}, int'(sif.coord_valid), 0);
  endtask

  task automatic full_frame(input int tw, input int th, input int sw, input int sh,
                            input int hk, input int vk, input int mode);
    start_frame(tw, th, sw, sh, hk, vk);
    walk(0, mode, fin);
    chk("frame_finished", int'(fin), 1);
    expect_done_pulse();
    expect_idle("after_done");
  endtask

  initial begin
    sif.frame_start = 1'b0;
    sif.coord_ready = 1'b0;
    scramble_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(sif.coord_valid), 0);
    chk("rst_busy", int'(sif.busy), 0);
    chk("rst_frame_done", int'(sif.frame_done), 0);
    chk("rst_dst_x", int'(sif.dst_x), 0);
    chk("rst_src_x", int'(sif.src_x), 0);
    chk("rst_frac_y", int'(sif.frac_y), 0);
    chk("rst_line_end", int'(sif.line_end), 0);
    chk("rst_frame_end", int'(sif.frame_end), 0);
    rst_n = 1'b1;

    full_frame(4, 2, 4, 2, int'(K_UNITY), int'(K_UNITY), 0);
    full_frame(6, 2, 6, 2, 256, 256, 2);
    full_frame(3, 1, 8, 1, 329, 256, 1);
    full_frame(8, 2, 4, 2, 180, 300, 1);

    start_frame(1024, 768, 640, 480, 160, 160);
    walk(1028, 0, fin);
    chk("upscale_partial", int'(fin), 0);

    start_frame(6, 3, 6, 3, 256, 256);
    walk(11, 1, fin);
    full_frame(2, 2, 5, 5, 300, 700, 1);

    start_frame(3, 2, 9, 9, 200, 400);
    walk(0, 1, fin);
    expect_done_pulse();
    full_frame(2, 3, 2, 2, 512, 128, 0);

    repeat (20) begin
      full_frame(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
                 int'($urandom_range(0, 8)), int'($urandom_range(0, 8)),
                 int'($urandom_range(0, 1000)), int'($urandom_range(0, 1000)), 1);
    end

    start_frame(0, 3, 4, 4, 256, 256);
    repeat (3) expect_idle("zero_width");
    start_frame(4, 0, 4, 4, 256, 256);
    repeat (3) expect_idle("zero_height");

    start_frame(5, 3, 5, 3, 256, 256);
    walk(3, 0, fin);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(sif.coord_valid), 0);
    chk("arst_busy", int'(sif.busy), 0);
    chk("arst_dst_x", int'(sif.dst_x), 0);
    chk("arst_src_x", int'(sif.src_x), 0);
    chk("arst_line_end", int'(sif.line_end), 0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_idle("after_arst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
